// File: rtl/ll_multi_fifo.sv
// ll_multi_fifo: NUM_FIFOS logical FIFOs sharing one DEPTH-entry data memory.
// Each entry carries a next-pointer. Every FIFO is a singly linked list, and
// the free entries form one more linked list through the same next-pointers.
// Push and pop may be accepted in the same cycle. When the memory is full,
// a push can reuse the entry that a simultaneous pop releases.
module ll_multi_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int NUM_FIFOS = 4,
  parameter int PTR_W     = $clog2(DEPTH),
  parameter int SEL_W     = $clog2(NUM_FIFOS),
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_en,
  input  logic [SEL_W-1:0]           push_sel,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       pop_en,
  input  logic [SEL_W-1:0]           pop_sel,
  output logic                       full,
  output logic [NUM_FIFOS-1:0]       empty,
  output logic [NUM_FIFOS*CNT_W-1:0] count,
  output logic [CNT_W-1:0]           free_cnt,
  output logic [WIDTH-1:0]           data_out,
  output logic                       out_valid,
  output logic                       err
);

  logic [WIDTH-1:0] mem_q       [DEPTH];
  logic [WIDTH-1:0] mem_d       [DEPTH];
  logic [PTR_W-1:0] nxt_q       [DEPTH];
  logic [PTR_W-1:0] nxt_d       [DEPTH];
  logic [PTR_W-1:0] head_q      [NUM_FIFOS];
  logic [PTR_W-1:0] head_d      [NUM_FIFOS];
  logic [PTR_W-1:0] tail_q      [NUM_FIFOS];
  logic [PTR_W-1:0] tail_d      [NUM_FIFOS];
  logic [CNT_W-1:0] cnt_q       [NUM_FIFOS];
  logic [CNT_W-1:0] cnt_d       [NUM_FIFOS];
  logic [PTR_W-1:0] free_head_q, free_head_d;
  logic [PTR_W-1:0] free_tail_q, free_tail_d;
  logic [CNT_W-1:0] free_cnt_q,  free_cnt_d;
  logic [WIDTH-1:0] data_out_q,  data_out_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q,       err_d;

  logic             push_in_range;
  logic             pop_in_range;
  logic             mem_full;
  logic             pa;
  logic             ua;
  logic             reuse;
  logic             take_free;
  logic             give_free;
  logic [PTR_W-1:0] freed;
  logic [PTR_W-1:0] target;

  // Decide which requests are accepted, judged only on the state before the edge.
  always_comb begin
    push_in_range = ({1'b0, push_sel} < (SEL_W + 1)'(NUM_FIFOS));
    pop_in_range  = ({1'b0, pop_sel} < (SEL_W + 1)'(NUM_FIFOS));
    mem_full      = (free_cnt_q == {CNT_W{1'b0}});
    pa            = pop_en & pop_in_range & (cnt_q[pop_sel] != {CNT_W{1'b0}});
    ua            = push_en & push_in_range & (~mem_full | pa);
    freed         = head_q[pop_sel];
    // With no free entry, a push may only go into the entry the pop just released.
    reuse         = ua & pa & mem_full;
    target        = reuse ? freed : free_head_q;
    take_free     = ua & ~reuse;
    give_free     = pa & ~reuse;
  end

  // Compute the next list, memory and output state from the accepted requests.
  always_comb begin
    mem_d       = mem_q;
    nxt_d       = nxt_q;
    head_d      = head_q;
    tail_d      = tail_q;
    cnt_d       = cnt_q;
    free_head_d = free_head_q;
    free_tail_d = free_tail_q;
    free_cnt_d  = free_cnt_q;

    // The pop side goes first, so that a push to the same FIFO can override head.
    if (pa) begin
      head_d[pop_sel] = nxt_q[freed];
      cnt_d[pop_sel]  = cnt_d[pop_sel] - CNT_W'(1);
    end else begin
      head_d[pop_sel] = head_d[pop_sel];
    end

    if (ua) begin
      mem_d[target] = data_in;
      if (cnt_q[push_sel] == {CNT_W{1'b0}}) begin
        head_d[push_sel] = target;
      end else begin
        nxt_d[tail_q[push_sel]] = target;
      end
      tail_d[push_sel] = target;
      cnt_d[push_sel]  = cnt_d[push_sel] + CNT_W'(1);
      // A single-entry FIFO popped and pushed together now holds only the new entry.
      if (pa && (pop_sel == push_sel) && (cnt_q[push_sel] == CNT_W'(1))) begin
        head_d[push_sel] = target;
      end else begin
        head_d[push_sel] = head_d[push_sel];
      end
    end else begin
      mem_d[target] = mem_d[target];
    end

    // Free list maintenance: take from the head, append released entries at the tail.
    case ({take_free, give_free})
      2'b10: begin
        free_head_d = nxt_q[free_head_q];
        free_cnt_d  = free_cnt_q - CNT_W'(1);
      end
      2'b01: begin
        if (free_cnt_q == {CNT_W{1'b0}}) begin
          free_head_d = freed;
        end else begin
          nxt_d[free_tail_q] = freed;
        end
        free_tail_d = freed;
        free_cnt_d  = free_cnt_q + CNT_W'(1);
      end
      2'b11: begin
        if (free_cnt_q == CNT_W'(1)) begin
          free_head_d = freed;
        end else begin
          free_head_d        = nxt_q[free_head_q];
          nxt_d[free_tail_q] = freed;
        end
        free_tail_d = freed;
      end
      default: begin
        free_cnt_d = free_cnt_q;
      end
    endcase

    data_out_d  = pa ? mem_q[freed] : data_out_q;
    out_valid_d = pa;
    err_d       = err_q | (push_en & ~ua) | (pop_en & ~pa);
  end

  // State registers; reset chains every entry into the free list in index order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
        nxt_q[i] <= PTR_W'(i + 1);
      end
      for (int f = 0; f < NUM_FIFOS; f++) begin
        head_q[f] <= {PTR_W{1'b0}};
        tail_q[f] <= {PTR_W{1'b0}};
        cnt_q[f]  <= {CNT_W{1'b0}};
      end
      free_head_q <= {PTR_W{1'b0}};
      free_tail_q <= PTR_W'(DEPTH - 1);
      free_cnt_q  <= CNT_W'(DEPTH);
      data_out_q  <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      nxt_q       <= nxt_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      cnt_q       <= cnt_d;
      free_head_q <= free_head_d;
      free_tail_q <= free_tail_d;
      free_cnt_q  <= free_cnt_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  // Every output is a register or a simple decode of registers.
  always_comb begin
    for (int f = 0; f < NUM_FIFOS; f++) begin
      count[CNT_W*f +: CNT_W] = cnt_q[f];
      empty[f]                = (cnt_q[f] == {CNT_W{1'b0}});
    end
    full      = (free_cnt_q == {CNT_W{1'b0}});
    free_cnt  = free_cnt_q;
    data_out  = data_out_q;
    out_valid = out_valid_q;
    err       = err_q;
  end

endmodule

// File: tb/tb_ll_multi_fifo.sv
// Bench for ll_multi_fifo. The reference model is a set of per-FIFO data
// queues plus the shared-capacity rule. Expected pop data goes into a
// scoreboard queue, and a monitor drains that queue whenever out_valid is high.
module tb_ll_multi_fifo;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int NF = 2;
  localparam int SW = 1;
  localparam int CW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             push_en = 1'b0, pop_en = 1'b0;
  logic [SW-1:0]    push_sel = '0, pop_sel = '0;
  logic [W-1:0]     data_in = '0;
  logic             full, out_valid, err;
  logic [NF-1:0]    empty;
  logic [NF*CW-1:0] count;
  logic [CW-1:0]    free_cnt;
  logic [W-1:0]     data_out;

  ll_multi_fifo #(.WIDTH(W), .DEPTH(D), .NUM_FIFOS(NF)) dut (
    .clk(clk), .rst(rst), .push_en(push_en), .push_sel(push_sel), .data_in(data_in),
    .pop_en(pop_en), .pop_sel(pop_sel), .full(full), .empty(empty), .count(count),
    .free_cnt(free_cnt), .data_out(data_out), .out_valid(out_valid), .err(err)
  );

  // Second instance with three FIFOs, so that a select value of 3 is out of range.
  logic          rst3 = 1'b1;
  logic          push3_en = 1'b0, pop3_en = 1'b0;
  logic [1:0]    push3_sel = '0, pop3_sel = '0;
  logic [W-1:0]  data3_in = '0;
  logic          full3, out3_valid, err3;
  logic [2:0]    empty3;
  logic [8:0]    count3;
  logic [CW-1:0] free3_cnt;
  logic [W-1:0]  data3_out;

  ll_multi_fifo #(.WIDTH(W), .DEPTH(D), .NUM_FIFOS(3)) dut3 (
    .clk(clk), .rst(rst3), .push_en(push3_en), .push_sel(push3_sel), .data_in(data3_in),
    .pop_en(pop3_en), .pop_sel(pop3_sel), .full(full3), .empty(empty3), .count(count3),
    .free_cnt(free3_cnt), .data_out(data3_out), .out_valid(out3_valid), .err(err3)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mq [NF][$];
  logic [W-1:0] exp_q [$];
  bit           m_err = 1'b0;
  bit           m_valid = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Compare every observable output against the reference model.
  task automatic check_state(input string tag);
    int total;
    int sum_cnt;
    total   = 0;
    sum_cnt = 0;
    for (int i = 0; i < NF; i++) begin
      chk($sformatf("%s_count%0d", tag, i), int'(count[CW*i +: CW]), mq[i].size());
      chk($sformatf("%s_empty%0d", tag, i), int'(empty[i]), (mq[i].size() == 0) ? 1 : 0);
      total   += mq[i].size();
      sum_cnt += int'(count[CW*i +: CW]);
    end
    chk({tag, "_free_cnt"}, int'(free_cnt), D - total);
    chk({tag, "_full"}, int'(full), (total == D) ? 1 : 0);
    chk({tag, "_err"}, int'(err), int'(m_err));
    chk({tag, "_out_valid"}, int'(out_valid), int'(m_valid));
    chk({tag, "_invariant"}, sum_cnt + int'(free_cnt), D);
  endtask

  // One clock of stimulus. The model advances using its own state before the edge.
  task automatic step(input string tag, input bit pe, input int ps, input logic [W-1:0] d,
                      input bit oe, input int os, input bit r);
    int  total;
    bit  pa;
    bit  ua;
    @(negedge clk);
    rst      = r;
    push_en  = pe;
    push_sel = ps[SW-1:0];
    data_in  = d;
    pop_en   = oe;
    pop_sel  = os[SW-1:0];
    if (r) begin
      for (int i = 0; i < NF; i++) mq[i].delete();
      exp_q.delete();
      m_err   = 1'b0;
      m_valid = 1'b0;
    end else begin
      total = 0;
      for (int i = 0; i < NF; i++) total += mq[i].size();
      pa = oe && (os < NF) && (mq[os].size() > 0);
      ua = pe && (ps < NF) && ((total < D) || pa);
      if (pa) exp_q.push_back(mq[os].pop_front());
      if (ua) mq[ps].push_back(d);
      if ((pe && !ua) || (oe && !pa)) m_err = 1'b1;
      m_valid = pa;
    end
    @(posedge clk);
    #1;
    check_state(tag);
    if (r) chk({tag, "_rst_data_out"}, int'(data_out), 0);
  endtask

  // Scoreboard monitor: each valid output must match the oldest expected pop.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("mon_unexpected_valid", 1, 0);
        end else begin
          chk("mon_data", int'(data_out), int'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    // Reset, then basic order across two FIFOs.
    step("rst0", 0, 0, 8'h00, 0, 0, 1);
    step("t1_push", 1, 1, 8'hA1, 0, 0, 0);
    step("t1_push", 1, 1, 8'hA2, 0, 0, 0);
    step("t1_push", 1, 0, 8'hB1, 0, 0, 0);
    step("t1_pop", 0, 0, 8'h00, 1, 1, 0);
    step("t1_pop", 0, 0, 8'h00, 1, 1, 0);
    step("t1_pop", 0, 0, 8'h00, 1, 0, 0);
    step("t1_idle", 0, 0, 8'h00, 0, 0, 0);
    chk("t1_empty_all", int'(empty), 3);

    // Fill the memory, push while full, then push and pop together while full.
    step("t2_fill", 1, 0, 8'h10, 0, 0, 0);
    step("t2_fill", 1, 0, 8'h11, 0, 0, 0);
    step("t2_fill", 1, 1, 8'h20, 0, 0, 0);
    step("t2_fill", 1, 1, 8'h21, 0, 0, 0);
    chk("t2_full", int'(full), 1);
    step("t2_reject", 1, 0, 8'h99, 0, 0, 0);
    chk("t2_err", int'(err), 1);
    step("t2_fullswap", 1, 0, 8'h12, 1, 1, 0);
    chk("t2_full_kept", int'(full), 1);
    chk("t2_data20", int'(data_out), 8'h20);
    for (int i = 0; i < 4; i++) step("t2_drain", 0, 0, 8'h00, 1, (i < 3) ? 0 : 1, 0);

    // A single-entry FIFO pushed and popped in the same cycle.
    step("rst1", 0, 0, 8'h00, 0, 0, 1);
    step("t3_push", 1, 0, 8'h55, 0, 0, 0);
    step("t3_swap", 1, 0, 8'h66, 1, 0, 0);
    chk("t3_data55", int'(data_out), 8'h55);
    step("t3_pop", 0, 0, 8'h00, 1, 0, 0);
    chk("t3_data66", int'(data_out), 8'h66);

    // Pop of an empty FIFO together with a push to the same FIFO.
    step("t4_pushpop", 1, 1, 8'h77, 1, 1, 0);
    step("t4_pop", 0, 0, 8'h00, 1, 1, 0);
    chk("t4_data77", int'(data_out), 8'h77);

    // Random traffic, with a reset partway through.
    step("rst2", 0, 0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 1000; i++) begin
      step((i == 500) ? "rnd_rst" : "rnd", 1'($urandom_range(0, 1)), int'($urandom_range(0, NF - 1)),
           8'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, NF - 1)), i == 500);
    end
    for (int i = 0; i < 2 * D; i++) step("drain", 0, 0, 8'h00, 1, i % NF, 0);
    step("final_idle", 0, 0, 8'h00, 0, 0, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    // Select value beyond the last FIFO, on the three-FIFO instance.
    @(negedge clk);
    rst3 = 1'b0;
    push3_en = 1'b1;
    push3_sel = 2'd3;
    data3_in = 8'h5A;
    @(posedge clk);
    #1;
    chk("sel_oob_err", int'(err3), 1);
    chk("sel_oob_free_cnt", int'(free3_cnt), D);
    chk("sel_oob_empty", int'(empty3), 7);
    @(negedge clk);
    push3_sel = 2'd2;
    @(posedge clk);
    #1;
    chk("sel2_free_cnt", int'(free3_cnt), D - 1);
    chk("sel2_count", int'(count3[8:6]), 1);
    @(negedge clk);
    push3_en = 1'b0;
    pop3_en = 1'b1;
    pop3_sel = 2'd2;
    @(posedge clk);
    #1;
    chk("sel2_valid", int'(out3_valid), 1);
    chk("sel2_data", int'(data3_out), 8'h5A);
    @(negedge clk);
    pop3_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
